// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency instruction ROM: owns the PC, feeds decode
// through a valid/stall handshake with a one-entry hold buffer, and shares the port with debug.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data
);

  logic [31:0] pc_q, pc_d, fpc_q, fpc_d, hpc_q, hpc_d, hbuf_q, hbuf_d, rom_addr_q;
  logic        f_q, f_d, h_q, h_d, d_q, rr_q, rr_d;
  logic        busy, accept, slot, dbg_want, dbg_issue, fetch_issue;
  logic        unused_low_bits;

  assign unused_low_bits = ^{dbg_addr[1:0], redirect_pc[1:0], RESET_PC[1:0]};

  assign busy       = h_q | f_q;
  assign inst_valid = busy & ~redirect_valid;
  assign accept     = inst_valid & ~stall;

  // Gating with reset keeps rom_addr at 0 while reset is held, even if RESET_PC != 0.
  assign slot        = reset & ~redirect_valid & (~busy | ~stall);
  assign dbg_want    = dbg_req & ~d_q;
  assign dbg_issue   = slot & dbg_want & ~rr_q;
  assign fetch_issue = slot & ~dbg_issue;

  always_comb begin
    inst_out = 32'h0;
    inst_pc  = 32'h0;
    if (inst_valid) begin
      inst_out = h_q ? hbuf_q : rom_data;
      inst_pc  = h_q ? hpc_q  : fpc_q;
    end
  end

  always_comb begin
    rom_addr = rom_addr_q;
    if (dbg_issue)        rom_addr = {dbg_addr[31:2], 2'b00};
    else if (fetch_issue) rom_addr = pc_q;
  end

  assign dbg_ack  = d_q;
  assign dbg_data = d_q ? rom_data : 32'h0;

  always_comb begin
    pc_d   = pc_q;
    fpc_d  = fpc_q;
    f_d    = fetch_issue;
    h_d    = h_q;
    hbuf_d = hbuf_q;
    hpc_d  = hpc_q;
    rr_d   = rr_q;
    if (fetch_issue) begin
      pc_d  = pc_q + 32'd4;
      fpc_d = pc_q;
      rr_d  = 1'b0;
    end
    if (dbg_issue) rr_d = 1'b1;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      h_d  = 1'b0;
    end else if (f_q && !accept) begin
      // Stalled item is parked so the ROM port is free on release.
      h_d    = 1'b1;
      hbuf_d = rom_data;
      hpc_d  = fpc_q;
    end else if (h_q && accept) begin
      h_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= {RESET_PC[31:2], 2'b00};
      fpc_q      <= 32'h0;
      hpc_q      <= 32'h0;
      hbuf_q     <= 32'h0;
      rom_addr_q <= 32'h0;
      f_q        <= 1'b0;
      h_q        <= 1'b0;
      d_q        <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fpc_q      <= fpc_d;
      hpc_q      <= hpc_d;
      hbuf_q     <= hbuf_d;
      rom_addr_q <= rom_addr;
      f_q        <= f_d;
      h_q        <= h_d;
      d_q        <= dbg_issue;
      rr_q       <= rr_d;
    end
  end

endmodule
